// File: rtl/fp_div_seq.sv
// fp_div_seq: multi-cycle IEEE-754 divider (in1 / in2).
// A radix-2 restoring divider produces one quotient bit per cycle. One
// normalise/round cycle follows, and the result is held until it is accepted.
// Special operands bypass the divider and are ready one cycle after accept.
// Subnormal operands are flushed to signed zero.
module fp_div_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int W    = 1 + EXP_W + MAN_W,
    localparam int BIAS = 2**(EXP_W-1) - 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in1,
    input  logic [W-1:0] in2,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] final_res,
    output logic         div_by_zero,
    output logic         invalid
);

    localparam int SW    = MAN_W + 1;   // significand including hidden one
    localparam int RW    = MAN_W + 2;   // partial remainder (one headroom bit)
    localparam int QW    = MAN_W + 3;   // quotient: integer bit, fraction, guard, extra
    localparam int EW    = EXP_W + 2;   // signed working exponent
    localparam int CNT_W = $clog2(QW);

    localparam logic [CNT_W-1:0]     LAST_STEP = CNT_W'(QW - 1);
    localparam logic signed [EW-1:0] BIAS_E    = EW'(BIAS);
    localparam logic signed [EW-1:0] EMAX      = EW'((2**EXP_W) - 1);
    localparam logic signed [EW-1:0] ONE_E     = EW'(1);
    localparam logic signed [EW-1:0] ZERO_E    = '0;
    localparam logic [W-1:0]         QNAN      = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_nxt;

    // Operand fields and classes
    logic               sa, sb, s_q;
    logic [EXP_W-1:0]   ea, eb;
    logic [MAN_W-1:0]   fa, fb;
    logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

    // Special-case result for the operands currently presented
    logic               spec_hit;
    logic [W-1:0]       spec_word;
    logic               spec_dbz;
    logic               spec_inv;

    // Divider datapath
    logic                    sign_r;
    logic signed [EW-1:0]    e_r;
    logic [RW-1:0]           rem_r;
    logic [SW-1:0]           div_r;
    logic [QW-1:0]           q_r;
    logic [CNT_W-1:0]        cnt_r;
    logic                    q_bit;
    logic [RW-1:0]           rem_sub;

    // Held result
    logic [W-1:0]            final_r;
    logic                    dbz_r;
    logic                    inv_r;

    logic                    accept;

    assign sa = in1[W-1];
    assign ea = in1[W-2:MAN_W];
    assign fa = in1[MAN_W-1:0];
    assign sb = in2[W-1];
    assign eb = in2[W-2:MAN_W];
    assign fb = in2[MAN_W-1:0];
    assign s_q = sa ^ sb;

    assign a_nan  = (&ea) &  (|fa);
    assign b_nan  = (&eb) &  (|fb);
    assign a_inf  = (&ea) & ~(|fa);
    assign b_inf  = (&eb) & ~(|fb);
    assign a_zero = ~(|ea);
    assign b_zero = ~(|eb);

    assign accept = in_valid & in_ready;

    // Pack sign/exponent/fraction, saturating to inf on overflow and to zero on underflow
    function automatic logic [W-1:0] saturate(input logic s,
                                              input logic signed [EW-1:0] e,
                                              input logic [MAN_W-1:0] frac);
        if (e >= EMAX)
            return {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (e <= ZERO_E)
            return {s, {(W-1){1'b0}}};
        else
            return {s, e[EXP_W-1:0], frac};
    endfunction

    // Normalise the raw quotient, round to nearest even, then range-check
    function automatic logic [W-1:0] round_pack(input logic s,
                                                input logic signed [EW-1:0] e_in,
                                                input logic [QW-1:0] q,
                                                input logic rem_nz);
        logic [QW-1:0]        qn;
        logic signed [EW-1:0] e;
        logic [SW-1:0]        mant;
        logic [SW:0]          mant_r;
        logic                 guard;
        logic                 sticky;
        logic                 rup;
        if (q[QW-1]) begin
            qn = q;
            e  = e_in;
        end else begin
            // ratio below one: the next bit is guaranteed set
            qn = q << 1;
            e  = e_in - ONE_E;
        end
        mant   = qn[QW-1:2];
        guard  = qn[1];
        sticky = qn[0] | rem_nz;
        rup    = guard & (sticky | mant[0]);
        mant_r = {1'b0, mant} + {{SW{1'b0}}, rup};
        if (mant_r[SW]) begin
            // carry out of rounding leaves 10.00..0; renormalise
            e      = e + ONE_E;
            mant_r = mant_r >> 1;
        end
        return saturate(s, e, mant_r[MAN_W-1:0]);
    endfunction

    // Classify the presented operands by priority into a special result
    always_comb begin
        spec_hit  = 1'b0;
        spec_word = '0;
        spec_dbz  = 1'b0;
        spec_inv  = 1'b0;
        if (a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf)) begin
            spec_hit  = 1'b1;
            spec_word = QNAN;
            spec_inv  = 1'b1;
        end else if (a_inf) begin
            spec_hit  = 1'b1;
            spec_word = {s_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (b_zero) begin
            spec_hit  = 1'b1;
            spec_word = {s_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            spec_dbz  = 1'b1;
        end else if (a_zero | b_inf) begin
            spec_hit  = 1'b1;
            spec_word = {s_q, {(W-1){1'b0}}};
        end
    end

    // One restoring step: subtract the divisor when it fits
    always_comb begin
        q_bit   = (rem_r >= {1'b0, div_r});
        rem_sub = q_bit ? (rem_r - {1'b0, div_r}) : rem_r;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept)              state_nxt = spec_hit ? DONE : DIV;
            DIV:  if (cnt_r == LAST_STEP)  state_nxt = NORM;
            NORM:                          state_nxt = DONE;
            DONE: if (out_ready)           state_nxt = IDLE;
            default:                       state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Operand capture, iterative divide, rounding and result hold
    always_ff @(posedge clk) begin
        if (rst) begin
            final_r <= '0;
            dbz_r   <= 1'b0;
            inv_r   <= 1'b0;
            cnt_r   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sign_r <= s_q;
                        e_r    <= $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS_E;
                        rem_r  <= {1'b0, 1'b1, fa};
                        div_r  <= {1'b1, fb};
                        q_r    <= '0;
                        cnt_r  <= '0;
                        dbz_r  <= spec_dbz;
                        inv_r  <= spec_inv;
                        if (spec_hit)
                            final_r <= spec_word;
                    end
                end
                DIV: begin
                    // remainder after subtract is below the divisor, so the shift is lossless
                    rem_r <= rem_sub << 1;
                    q_r   <= {q_r[QW-2:0], q_bit};
                    cnt_r <= cnt_r + CNT_W'(1);
                end
                NORM: begin
                    final_r <= round_pack(sign_r, e_r, q_r, |rem_r);
                end
                DONE: begin
                    if (out_ready) begin
                        dbz_r <= 1'b0;
                        inv_r <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign final_res   = final_r;
    assign div_by_zero = dbz_r;
    assign invalid     = inv_r;

endmodule

// File: doc/fp_div_seq.md
Name: fp_div_seq

Overview:
Parametrised, multi-cycle IEEE-754 floating-point divider that computes in1 / in2. It uses a radix-2 restoring mantissa divider with round-to-nearest-even and full special-case handling. It is the sequential, handshaked successor to the combinational single-precision divider. It sits in the FP arithmetic cluster and targets binary32 by default, with binary16 and binary64 selectable via parameters.

Parameters:
EXP_W, 8, exponent field width
MAN_W, 23, stored mantissa (fraction) width; word width W = 1+EXP_W+MAN_W
BIAS, 2**(EXP_W-1)-1, exponent bias (derived; not for override)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  operands presented
in_ready  out  1  block can accept operands
in1  in  W  dividend, IEEE-754
in2  in  W  divisor, IEEE-754
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
final  out  W  quotient, IEEE-754
div_by_zero  out  1  finite nonzero / zero occurred
invalid  out  1  NaN operand, 0/0 or inf/inf

Behaviour:
- Reset, synchronous, in any state: state=IDLE, in_ready=1, out_valid=0, final=0, div_by_zero=0, invalid=0. An in-flight operation is discarded.
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready, operands are registered and classified. Special case -> DONE. Normal -> DIV.
  - DIV: one quotient bit per cycle, for exactly MAN_W+3 cycles (iteration counter). Then -> NORM.
  - NORM: normalise, round, exponent check. Then -> DONE.
  - DONE: out_valid=1. On out_ready -> IDLE.
- in_ready is 1 only in IDLE. No overlap between operations: the next accept is no earlier than the cycle after the handshake completes.
- Latency, measured from the accept edge T:
  - Special case: out_valid from T+1.
  - Normal: out_valid from T+MAN_W+5, which is 28 cycles for binary32.
- While out_valid=1, final, div_by_zero and invalid hold stable until the out handshake completes. Flags are valid only with out_valid; they clear on leaving DONE.
- Sign of every non-NaN result = in1.sign XOR in2.sign.
- Subnormal inputs (exp=0, frac!=0) are treated as signed zero (flush to zero).
- Special-case priority:
  1. Either operand NaN, or 0/0, or inf/inf -> canonical qNaN: sign 0, exp all ones, frac MSB only. invalid=1.
  2. inf/x (x finite) -> signed inf.
  3. Finite nonzero / 0 -> signed inf, div_by_zero=1.
  4. 0/x (x nonzero) or finite/inf -> signed zero.
- Normal path:
  - Dividend significand A={1,fracA}, divisor B={1,fracB}.
  - Restoring divide of A by B yields MAN_W+3 quotient bits with integer weight 2^0 (ratio lies in [0.5,2)).
  - sticky = (final remainder != 0).
  - If the quotient MSB is 0: shift left 1 and exponent -1.
  - Biased exponent e = eA - eB + BIAS (signed, EXP_W+2 bits).
  - Round to nearest even using guard bit + sticky. A rounding carry renormalises and increments e.
- Range checks after rounding:
  - e >= 2**EXP_W-1 -> signed inf (overflow).
  - e <= 0 -> signed zero (flush to zero).
- in1/in2 are sampled only at the accept edge. Later changes have no effect.

Test Plan:
- 6.0/2.0 (0x40C00000/0x40000000) -> final=0x40400000, flags 0, out_valid exactly 28 cycles after accept.
- 1.0/3.0 (0x3F800000/0x40400000) -> final=0x3EAAAAAB (RNE round-up). -2.0/2.0 (0xC0000000/0x40000000) -> 0xBF800000.
- Specials, each at latency 1:
  - 1.0/0.0 -> 0x7F800000, div_by_zero=1.
  - inf/-inf (0x7F800000/0xFF800000) -> 0x7FC00000, invalid=1.
  - 0xFFFFFFFF/1.0 -> 0x7FC00000, invalid=1.
  - 1.0/inf -> 0x00000000.
- Range:
  - 0x7F7FFFFF/0x3F000000 -> 0x7F800000, flags 0.
  - 0x00800000/0x40000000 -> 0x00000000 (flush to zero).
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles in DONE: final stable, in_ready=0. in1 changes after accept have no effect.
  - Assert rst during DIV: out_valid stays 0 and in_ready=1 next cycle. A new 6.0/2.0 then completes correctly.
- Parameter set EXP_W=5, MAN_W=10: 0x4200/0x4000 (3.0/2.0) -> 0x3E00, latency 15 cycles. 0x3C00/0x0000 -> 0x7C00 with div_by_zero=1.
